// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-client block RAM access controller.
package bram_arbiter_pkg;

  // Client identity; doubles as the round-robin pointer value.
  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_t;

  // Controller phases: zero-fill sweep, then normal request service.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Request opcode as carried on the *_we inputs.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/bram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the client that wins a tie
// and always moves to the other client after any grant.
module rr_arbiter2
  import bram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output client_t    o_sel
);

  client_t    r_ptr;
  logic [1:0] w_gnt;

  // Grant a lone requester directly; on a tie the pointer owner wins.
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        w_gnt = (r_ptr == CLIENT_A) ? 2'b01 : 2'b10;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  // Hand priority to whichever client did not just win; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CLIENT_A;
    end else if (w_gnt[0]) begin
      r_ptr <= CLIENT_B;
    end else if (w_gnt[1]) begin
      r_ptr <= CLIENT_A;
    end
  end

  assign o_gnt = w_gnt;
  assign o_sel = w_gnt[1] ? CLIENT_B : CLIENT_A;

endmodule

// File: rtl/bram_arbiter.sv
// Two-client controller for a simple-dual-port block RAM with registered
// read data. Optionally zero-fills the whole memory after reset, then
// serves one single-word read or write per cycle with round-robin fairness.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_SERVE;
  localparam logic                  RESET_DONE  = (CLEAR_ON_RESET == 0);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_init_done;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;

  logic                  w_serve;
  logic [1:0]            w_gnt;
  client_t               w_sel;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  logic                  w_mem_write;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [ADDR_WIDTH-1:0] w_mem_raddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_a;
  logic                  w_rd_b;

  assign w_serve = (r_state == ST_SERVE);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_serve),
    .i_req ({b_req, a_req}),
    .o_gnt (w_gnt),
    .o_sel (w_sel)
  );

  assign w_sel_we    = (w_sel == CLIENT_B) ? b_we    : a_we;
  assign w_sel_addr  = (w_sel == CLIENT_B) ? b_addr  : a_addr;
  assign w_sel_wdata = (w_sel == CLIENT_B) ? b_wdata : a_wdata;

  // Next-state and memory port steering: sweep writes during INIT, the
  // granted client's access during SERVE, quiet ports otherwise.
  always_comb begin
    w_state_next = r_state;
    w_mem_write  = 1'b0;
    w_mem_waddr  = '0;
    w_mem_raddr  = '0;
    w_mem_wdata  = '0;
    w_rd_a       = 1'b0;
    w_rd_b       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mem_write = 1'b1;
        w_mem_waddr = r_count;
        if (r_count == LAST_ADDR) begin
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_gnt != 2'b00) begin
          if (w_sel_we == OP_WRITE) begin
            w_mem_write = 1'b1;
            w_mem_waddr = w_sel_addr;
            w_mem_wdata = w_sel_wdata;
          end else begin
            w_mem_raddr = w_sel_addr;
            w_rd_a      = w_gnt[0];
            w_rd_b      = w_gnt[1];
          end
        end
      end
      default: begin
        w_state_next = ST_SERVE;
      end
    endcase
  end

  // Phase register; reset re-enters the sweep when clearing is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sweep address counter, only advancing while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_state == ST_INIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Ready flag rises the cycle after the last sweep address is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_done <= RESET_DONE;
    end else if ((r_state == ST_INIT) && (r_count == LAST_ADDR)) begin
      r_init_done <= 1'b1;
    end
  end

  // Read ownership tracks the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_rd_a;
      r_b_rvalid <= w_rd_b;
    end
  end

  assign a_gnt     = w_gnt[0];
  assign b_gnt     = w_gnt[1];
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign rdata     = mem_rdata;
  assign init_done = r_init_done;
  assign mem_write = w_mem_write;
  assign mem_waddr = w_mem_waddr;
  assign mem_raddr = w_mem_raddr;
  assign mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a clearing instance (4-bit address) with a
// behavioural block RAM, plus a non-clearing instance for the immediate
// service case. Expected read data is queued when a read grant is expected
// and popped in the following cycle.
module tb_bram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  logic          aReq, aWe, bReq, bWe;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aWdata, bWdata;
  logic          aGnt, bGnt, aRvalid, bRvalid, initDone, memWrite;
  logic [AW-1:0] memWaddr, memRaddr;
  logic [DW-1:0] memWdata, memRdata, rdata;

  logic          aReq2, aWe2, bReq2, bWe2;
  logic [AW-1:0] aAddr2, bAddr2;
  logic [DW-1:0] aWdata2, bWdata2;
  logic          aGnt2, bGnt2, aRvalid2, bRvalid2, initDone2, memWrite2;
  logic [AW-1:0] memWaddr2, memRaddr2;
  logic [DW-1:0] memWdata2, memRdata2, rdata2;

  typedef struct packed {
    logic          client;
    logic [DW-1:0] data;
  } expRead_t;

  expRead_t      scoreQ[$];
  logic [DW-1:0] shadow [16];
  int            checkCount = 0;
  int            errorCount = 0;

  logic [DW-1:0] memArray  [16];
  logic [DW-1:0] memArray2 [16];
  logic          memLoaded  = 1'b0;
  logic          memLoaded2 = 1'b0;

  always #5 clk = ~clk;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_gnt(aGnt), .a_rvalid(aRvalid),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_gnt(bGnt), .b_rvalid(bRvalid),
    .rdata(rdata), .init_done(initDone),
    .mem_write(memWrite), .mem_waddr(memWaddr), .mem_raddr(memRaddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst(rst),
    .a_req(aReq2), .a_we(aWe2), .a_addr(aAddr2), .a_wdata(aWdata2),
    .a_gnt(aGnt2), .a_rvalid(aRvalid2),
    .b_req(bReq2), .b_we(bWe2), .b_addr(bAddr2), .b_wdata(bWdata2),
    .b_gnt(bGnt2), .b_rvalid(bRvalid2),
    .rdata(rdata2), .init_done(initDone2),
    .mem_write(memWrite2), .mem_waddr(memWaddr2), .mem_raddr(memRaddr2),
    .mem_wdata(memWdata2), .mem_rdata(memRdata2)
  );

  // Behavioural block RAM for the clearing instance, preloaded with 0xEE
  // so that a missing zero-fill is visible on readback.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 16; i++) memArray[i] <= 8'hEE;
      memLoaded <= 1'b1;
    end else if (memWrite) begin
      memArray[memWaddr] <= memWdata;
    end
    if (rst) memRdata <= '0;
    else if (!memWrite) memRdata <= memArray[memRaddr];
  end

  // Behavioural block RAM for the non-clearing instance.
  always @(posedge clk) begin
    if (!memLoaded2) begin
      for (int i = 0; i < 16; i++) memArray2[i] <= 8'hEE;
      memLoaded2 <= 1'b1;
    end else if (memWrite2) begin
      memArray2[memWaddr2] <= memWdata2;
    end
    if (rst) memRdata2 <= '0;
    else if (!memWrite2) memRdata2 <= memArray2[memRaddr2];
  end

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Compare this cycle's read response against what the previous cycle queued.
  task automatic checkResponses();
    expRead_t e;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput("a_rvalid", {31'd0, aRvalid}, {31'd0, e.client == 1'b0});
      checkOutput("b_rvalid", {31'd0, bRvalid}, {31'd0, e.client == 1'b1});
      checkOutput("rdata", {24'd0, rdata}, {24'd0, e.data});
    end else begin
      checkOutput("a_rvalid idle", {31'd0, aRvalid}, 32'd0);
      checkOutput("b_rvalid idle", {31'd0, bRvalid}, 32'd0);
    end
  endtask

  // Memory port checks and scoreboard update for an expected grant.
  task automatic grantEffect(input logic client, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (we) begin
      checkOutput("mem_write wr", {31'd0, memWrite}, 32'd1);
      checkOutput("mem_waddr", {28'd0, memWaddr}, {28'd0, addr});
      checkOutput("mem_wdata", {24'd0, memWdata}, {24'd0, data});
      shadow[addr] = data;
    end else begin
      checkOutput("mem_write rd", {31'd0, memWrite}, 32'd0);
      checkOutput("mem_raddr", {28'd0, memRaddr}, {28'd0, addr});
      scoreQ.push_back('{client: client, data: shadow[addr]});
    end
  endtask

  // One SERVE cycle on the clearing instance: drive, check, advance.
  task automatic applyStimulus(input logic ar, input logic aw, input logic [AW-1:0] aa,
                               input logic [DW-1:0] ad, input logic br, input logic bw,
                               input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                               input logic expA, input logic expB);
    aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
    bReq = br; bWe = bw; bAddr = ba; bWdata = bd;
    @(negedge clk);
    checkResponses();
    checkOutput("a_gnt", {31'd0, aGnt}, {31'd0, expA});
    checkOutput("b_gnt", {31'd0, bGnt}, {31'd0, expB});
    if (expA) grantEffect(1'b0, aw, aa, ad);
    else if (expB) grantEffect(1'b1, bw, ba, bd);
    else begin
      checkOutput("mem_write idle", {31'd0, memWrite}, 32'd0);
      checkOutput("mem_raddr idle", {28'd0, memRaddr}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Zero-fill sweep: 16 writes of 0 to addresses 0..15 while both clients wait.
  task automatic checkSweep();
    aReq = 1'b1; aWe = 1'b0; aAddr = 4'd5; aWdata = 8'h00;
    bReq = 1'b1; bWe = 1'b1; bAddr = 4'd2; bWdata = 8'h99;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkResponses();
      checkOutput("sweep mem_write", {31'd0, memWrite}, 32'd1);
      checkOutput("sweep mem_waddr", {28'd0, memWaddr}, i);
      checkOutput("sweep mem_wdata", {24'd0, memWdata}, 32'd0);
      checkOutput("sweep a_gnt", {31'd0, aGnt}, 32'd0);
      checkOutput("sweep b_gnt", {31'd0, bGnt}, 32'd0);
      checkOutput("sweep init_done", {31'd0, initDone}, 32'd0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    checkOutput("init_done after sweep", {31'd0, initDone}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    aReq = 0; aWe = 0; aAddr = 0; aWdata = 0; bReq = 0; bWe = 0; bAddr = 0; bWdata = 0;
    aReq2 = 0; aWe2 = 0; aAddr2 = 0; aWdata2 = 0; bReq2 = 0; bWe2 = 0; bAddr2 = 0; bWdata2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset init_done", {31'd0, initDone}, 32'd0);
    checkOutput("reset a_rvalid", {31'd0, aRvalid}, 32'd0);
    checkOutput("reset b_rvalid", {31'd0, bRvalid}, 32'd0);
    checkOutput("reset init_done2", {31'd0, initDone2}, 32'd1);
    rst = 1'b0;
    checkSweep();

    // First SERVE cycle: tie goes to A; the read proves the sweep cleared 5.
    applyStimulus(1, 0, 4'd5, 8'h00, 1, 1, 4'd2, 8'h99, 1, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'h99, 0, 1);

    // A writes then reads back its own word.
    applyStimulus(1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'h00, 1, 0);
    applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // Preload, then continuous contention alternating A,B,A,B...
    applyStimulus(1, 1, 4'd1, 8'h11, 0, 0, 4'd0, 8'h00, 1, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'h22, 0, 1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00, (i % 2) == 0, (i % 2) == 1);
    applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // B writes 0x77 @9 while A waits, then A reads it.
    applyStimulus(1, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    applyStimulus(1, 0, 4'd9, 8'h00, 1, 1, 4'd9, 8'h77, 0, 1);
    applyStimulus(1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);

    // Top address and all-ones data.
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd15, 8'hFF, 0, 1);
    applyStimulus(1, 0, 4'd15, 8'h00, 1, 0, 4'd0, 8'h00, 1, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // Reset right after a granted read: no response afterwards, sweep restarts,
    // pointer (left at B) returns to A.
    applyStimulus(1, 0, 4'd15, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    rst = 1'b1;
    aReq = 0; bReq = 0;
    scoreQ.delete();
    @(posedge clk);
    #1;
    checkOutput("midreset a_rvalid", {31'd0, aRvalid}, 32'd0);
    checkOutput("midreset b_rvalid", {31'd0, bRvalid}, 32'd0);
    checkOutput("midreset init_done", {31'd0, initDone}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkSweep();
    applyStimulus(1, 0, 4'd5, 8'h00, 1, 1, 4'd2, 8'h99, 1, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'h99, 0, 1);
    applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // Non-clearing instance: ready out of reset, serves in the first cycle.
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("noclear init_done", {31'd0, initDone2}, 32'd1);
    rst = 1'b0;
    aReq2 = 1; aWe2 = 1; aAddr2 = 4'd7; aWdata2 = 8'h3C;
    @(negedge clk);
    checkOutput("noclear a_gnt", {31'd0, aGnt2}, 32'd1);
    checkOutput("noclear mem_write", {31'd0, memWrite2}, 32'd1);
    checkOutput("noclear mem_waddr", {28'd0, memWaddr2}, 32'd7);
    checkOutput("noclear mem_wdata", {24'd0, memWdata2}, 32'h3C);
    @(posedge clk);
    #1;
    aReq2 = 0;
    bReq2 = 1; bWe2 = 0; bAddr2 = 4'd7;
    @(negedge clk);
    checkOutput("noclear b_gnt", {31'd0, bGnt2}, 32'd1);
    checkOutput("noclear a_gnt idle", {31'd0, aGnt2}, 32'd0);
    checkOutput("noclear mem_raddr", {28'd0, memRaddr2}, 32'd7);
    @(posedge clk);
    #1;
    bReq2 = 0;
    @(negedge clk);
    checkOutput("noclear b_rvalid", {31'd0, bRvalid2}, 32'd1);
    checkOutput("noclear a_rvalid", {31'd0, aRvalid2}, 32'd0);
    checkOutput("noclear rdata", {24'd0, rdata2}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-client access controller for the team's synchronous simple-dual-port block RAM.
- Memory contract:
  - one write port and one read port;
  - a write suppresses the read in the same cycle;
  - read data is registered, 1-cycle latency;
  - memory rst clears read data.
- Arbitrates single-word read/write requests from clients A and B with round-robin fairness.
- Optionally zero-fills the memory after reset before serving requests.

Parameters:
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset; 0 = serve immediately.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  client A request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  client A address.
- a_wdata  in  DATA_WIDTH  client A write data.
- a_gnt  out  1  combinational; request accepted at this clock edge.
- a_rvalid  out  1  registered; rdata belongs to client A this cycle.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: identical to client A ports, for client B.
- rdata  out  DATA_WIDTH  read data, pass-through of mem_rdata.
- init_done  out  1  registered; high once serving.
- mem_write  out  1  to memory write strobe.
- mem_waddr  out  ADDR_WIDTH  to memory write address.
- mem_raddr  out  ADDR_WIDTH  to memory read address.
- mem_wdata  out  DATA_WIDTH  to memory write data.
- mem_rdata  in  DATA_WIDTH  from memory read data.

Behaviour:
- Reset values:
  - FSM = INIT if CLEAR_ON_RESET, else SERVE.
  - clear counter = 0.
  - round-robin pointer = A.
  - a_rvalid = b_rvalid = 0.
  - init_done = !CLEAR_ON_RESET.
- Reset mid-operation drops any pending rvalid and restarts INIT (if enabled).
- FSM INIT:
  - every cycle: mem_write=1, mem_waddr=counter, mem_wdata=0, mem_raddr=0; counter increments.
  - when counter = 2**ADDR_WIDTH-1 is written: go to SERVE, init_done=1 next cycle.
  - sweep takes exactly 2**ADDR_WIDTH cycles.
  - a_gnt = b_gnt = 0; requests wait.
- FSM SERVE: at most one access per cycle.
  - Exactly one req high: that client is granted.
  - Both high: pointer owner is granted.
  - After any grant: pointer = the other client. With no grant, pointer holds.
  - Granted write: mem_write=1, mem_waddr=addr, mem_wdata=wdata.
  - Granted read: mem_write=0, mem_raddr=addr; the owning client's rvalid is set next cycle, when rdata = mem_rdata.
  - No grant: mem_write=0, mem_raddr=0, no rvalid.
- Read latency: grant edge k -> rvalid/rdata valid in the cycle following edge k. Reads are throughput 1 per cycle, back-to-back.
- Writes produce no response.
- Read-after-write: a read granted in any cycle after the write's grant returns the new data. Same-cycle conflict is impossible by construction.
- a_rvalid and b_rvalid are never both high.
- At most one gnt is high per cycle; gnt is never high without its req.
- Latched requests are not used; clients own request stability.

Decomposition:
- Shared package:
  - client index type (A=0, B=1);
  - FSM state enum {INIT, SERVE};
  - op encoding constants (OP_READ=0, OP_WRITE=1).
- Optional sub-module rr_arbiter2: 2-way round-robin grant with pointer register, reusable by later multi-client controllers.
- The memory itself stays outside; it is instantiated alongside at the parent level.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4, rst then idle -> 16 consecutive mem_write cycles, addresses 0..15, data 0; init_done rises on cycle 17; no gnt before then.
- A writes 0x5A @3, then A reads @3 -> a_gnt each cycle; a_rvalid=1 with rdata=0x5A one cycle after the read grant; b_rvalid stays 0.
- A and B both request reads continuously (A @1, B @2) -> grants alternate A,B,A,B starting with A; rvalid alternates with rdata 0x11/0x22 (preloaded), one per cycle.
- B writes 0x77 @9 while A waits, then A reads @9 the next cycle -> A reads 0x77.
- Assert rst one cycle after a granted read -> no rvalid following; INIT sweep restarts from address 0; pointer back to A.
- CLEAR_ON_RESET=0 -> init_done=1 from reset; first request granted in the first cycle after rst deasserts.
